// File: rtl/seq_shift_add_multiplier_if.sv
// rtl/seq_shift_add_multiplier_if.sv - operand/product handshake bundle for seq_shift_add_multiplier
interface seq_shift_add_multiplier_if #(
    parameter int W = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
`ifdef MULT_SIGNED_EN
    logic           signed_mode;
`endif
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] o;

`ifdef MULT_SIGNED_EN
    modport master (output in_valid, x, y, signed_mode, out_ready,
                    input  in_ready, out_valid, o);
    modport slave  (input  in_valid, x, y, signed_mode, out_ready,
                    output in_ready, out_valid, o);
`else
    modport master (output in_valid, x, y, out_ready,
                    input  in_ready, out_valid, o);
    modport slave  (input  in_valid, x, y, out_ready,
                    output in_ready, out_valid, o);
`endif
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - W-cycle shift-and-add multiplier; MULT_SIGNED_EN adds two's-complement mode
module seq_shift_add_multiplier #(
    parameter int W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    seq_shift_add_multiplier_if.slave  bus
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [W:0]     acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] o_q, o_d;

    logic [W:0]     ext;
    logic [W:0]     addend;
    logic [W:0]     sum;
    logic           fill;
    logic           last;

    assign last   = (cnt_q == CW'(W - 1));
    assign addend = mplier_q[0] ? ext : '0;

`ifdef MULT_SIGNED_EN
    logic sgn_q, sgn_d;

    // The final multiplier bit carries weight -2^(W-1) in signed mode, hence the subtract.
    assign ext  = {sgn_q & mcand_q[W-1], mcand_q};
    assign sum  = (sgn_q && last) ? (acc_q - addend) : (acc_q + addend);
    assign fill = sgn_q & sum[W];
`else
    assign ext  = {1'b0, mcand_q};
    assign sum  = acc_q + addend;
    assign fill = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        o_d      = o_q;
`ifdef MULT_SIGNED_EN
        sgn_d    = sgn_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d  = bus.x;
                    mplier_d = bus.y;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef MULT_SIGNED_EN
                    sgn_d    = bus.signed_mode;
`endif
                    state_d  = CALC;
                end
            end
            CALC: begin
                // Shift {sum, mplier} right as one 2W+1-bit word; product bits fill mplier from the top.
                acc_d    = {fill, sum[W:1]};
                mplier_d = {sum[0], mplier_q[W-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (last) begin
                    o_d     = {sum, mplier_q[W-1:1]};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            o_q      <= '0;
`ifdef MULT_SIGNED_EN
            sgn_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            o_q      <= o_d;
`ifdef MULT_SIGNED_EN
            sgn_q    <= sgn_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.o         = o_q;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - directed vectors and randomized regression for seq_shift_add_multiplier
module tb_seq_shift_add_multiplier;
    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    bit   rand_go = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    seq_shift_add_multiplier_if #(.W(4)) b4 ();
    seq_shift_add_multiplier_if #(.W(8)) b8 ();
    seq_shift_add_multiplier #(.W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    seq_shift_add_multiplier #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sm;
        logic [7:0] p;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op4(input vec_t v, input string nm);
        int n;
        b4.x = v.a;
        b4.y = v.b;
`ifdef MULT_SIGNED_EN
        b4.signed_mode = v.sm;
`endif
        b4.in_valid  = 1'b1;
        b4.out_ready = 1'b1;
        check({nm, "_ready_idle"}, 64'(b4.in_ready), 64'd1);
        tick();
        b4.in_valid = 1'b0;
        b4.x = ~v.a;
        b4.y = ~v.b;
        check({nm, "_ready_busy"}, 64'(b4.in_ready), 64'd0);
        n = 0;
        while (!b4.out_valid && n < 20) begin
            tick();
            n++;
        end
        check({nm, "_latency"}, 64'(n), 64'd4);
        check({nm, "_o"}, 64'(b4.o), 64'(v.p));
        tick();
        check({nm, "_valid_after"}, 64'(b4.out_valid), 64'd0);
        check({nm, "_ready_after"}, 64'(b4.in_ready), 64'd1);
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_rand
        localparam int WW   = 2 << gi;
        localparam int NOPS = 2500;
        seq_shift_add_multiplier_if #(.W(WW)) rb ();
        seq_shift_add_multiplier #(.W(WW)) dut (.clk(clk), .rst_n(rst_n), .bus(rb.slave));
        logic [63:0] expq [$];
        logic [63:0] e;
        longint      ax, ay;
        int          acc_n, out_n;
        bit          done;

        initial begin
            rb.in_valid  = 1'b0;
            rb.out_ready = 1'b0;
            rb.x = '0;
            rb.y = '0;
`ifdef MULT_SIGNED_EN
            rb.signed_mode = 1'b0;
`endif
            done  = 1'b0;
            acc_n = 0;
            out_n = 0;
            wait (rand_go);
            for (int c = 0; c < 80000 && !(acc_n == NOPS && expq.size() == 0); c++) begin
                @(negedge clk);
                if (rb.in_valid && rb.in_ready) begin
                    ax = rb.x;
                    ay = rb.y;
`ifdef MULT_SIGNED_EN
                    if (rb.signed_mode) begin
                        ax = $signed(rb.x);
                        ay = $signed(rb.y);
                    end
`endif
                    expq.push_back(64'(ax * ay));
                    acc_n++;
                end
                if (rb.out_valid && rb.out_ready) begin
                    out_n++;
                    if (expq.size() == 0) begin
                        check($sformatf("rand_w%0d_extra_product", WW), 64'(out_n), 64'(acc_n - 1));
                    end else begin
                        e = expq.pop_front();
                        check($sformatf("rand_w%0d_o", WW), 64'(rb.o), 64'(e[2*WW-1:0]));
                    end
                end
                @(posedge clk);
                #1;
                rb.in_valid  = (acc_n < NOPS) && ($urandom_range(7) != 0);
                rb.x         = WW'($urandom);
                rb.y         = WW'($urandom);
                rb.out_ready = ($urandom_range(3) != 0);
`ifdef MULT_SIGNED_EN
                rb.signed_mode = 1'($urandom_range(1));
`endif
            end
            rb.in_valid = 1'b0;
            check($sformatf("rand_w%0d_accepted", WW), 64'(acc_n), 64'(NOPS));
            check($sformatf("rand_w%0d_delivered", WW), 64'(out_n), 64'(NOPS));
            done = 1'b1;
        end
    end

    initial begin
        vec_t tbl [$];
        int   n;

        tbl.push_back('{4'd15, 4'd15, 1'b0, 8'hE1});
        tbl.push_back('{4'd8,  4'd8,  1'b0, 8'h40});
        tbl.push_back('{4'd10, 4'd12, 1'b0, 8'h78});
        tbl.push_back('{4'd1,  4'd1,  1'b0, 8'h01});
        tbl.push_back('{4'd7,  4'd0,  1'b0, 8'h00});
`ifdef MULT_SIGNED_EN
        tbl.push_back('{4'h8,  4'h8,  1'b1, 8'h40});
        tbl.push_back('{4'h8,  4'h7,  1'b1, 8'hC8});
        tbl.push_back('{4'h7,  4'hF,  1'b1, 8'hF9});
        tbl.push_back('{4'hF,  4'hF,  1'b1, 8'h01});
        tbl.push_back('{4'h8,  4'h1,  1'b1, 8'hF8});
        b4.signed_mode = 1'b0;
        b8.signed_mode = 1'b0;
`endif
        b4.in_valid = 1'b0; b4.out_ready = 1'b0; b4.x = '0; b4.y = '0;
        b8.in_valid = 1'b0; b8.out_ready = 1'b0; b8.x = '0; b8.y = '0;

        tick();
        tick();
        check("reset_w4_in_ready", 64'(b4.in_ready), 64'd1);
        check("reset_w4_out_valid", 64'(b4.out_valid), 64'd0);
        check("reset_w4_o", 64'(b4.o), 64'd0);
        check("reset_w8_o", 64'(b8.o), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            op4(tbl[i], $sformatf("vec%0d", i));
        end

        // Operands held valid while busy; the second pair must only be taken after the first result drains.
        b4.x = 4'd0; b4.y = 4'd13; b4.in_valid = 1'b1; b4.out_ready = 1'b1;
        tick();
        b4.x = 4'd9; b4.y = 4'd1;
        n = 0;
        while (!b4.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("b2b_first_latency", 64'(n), 64'd4);
        check("b2b_first_o", 64'(b4.o), 64'h00);
        n = 0;
        do begin
            tick();
            n++;
        end while (!b4.out_valid && n < 20);
        check("b2b_spacing", 64'(n), 64'd6);
        check("b2b_second_o", 64'(b4.o), 64'h09);
        b4.in_valid = 1'b0;
        tick();
        check("b2b_drain_valid", 64'(b4.out_valid), 64'd0);
        tick();
        check("b2b_no_extra_valid", 64'(b4.out_valid), 64'd0);
        check("b2b_no_extra_ready", 64'(b4.in_ready), 64'd1);

        // Abort mid-calculation; o still holds 9 from above so a clear is observable.
        b4.x = 4'd5; b4.y = 4'd6; b4.in_valid = 1'b1;
        tick();
        b4.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_calc_out_valid", 64'(b4.out_valid), 64'd0);
        check("rst_calc_in_ready", 64'(b4.in_ready), 64'd1);
        check("rst_calc_o", 64'(b4.o), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_release_o", 64'(b4.o), 64'd0);
        check("rst_release_valid", 64'(b4.out_valid), 64'd0);
        op4('{4'd3, 4'd3, 1'b0, 8'd9}, "after_rst");

        b8.x = 8'd255; b8.y = 8'd255; b8.in_valid = 1'b1; b8.out_ready = 1'b0;
        tick();
        b8.in_valid = 1'b0;
        n = 0;
        while (!b8.out_valid && n < 40) begin
            tick();
            n++;
        end
        check("w8_latency", 64'(n), 64'd8);
        check("w8_o", 64'(b8.o), 64'hFE01);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("w8_hold%0d_valid", i), 64'(b8.out_valid), 64'd1);
            check($sformatf("w8_hold%0d_o", i), 64'(b8.o), 64'hFE01);
        end
        b8.out_ready = 1'b1;
        tick();
        check("w8_release_valid", 64'(b8.out_valid), 64'd0);
        check("w8_release_ready", 64'(b8.in_ready), 64'd1);

        rand_go = 1'b1;
        for (int c = 0; c < 90000 &&
             !(g_rand[0].done && g_rand[1].done && g_rand[2].done && g_rand[3].done); c++) begin
            @(posedge clk);
        end
        check("rand_all_finished",
              64'(g_rand[0].done && g_rand[1].done && g_rand[2].done && g_rand[3].done), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
